// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS data-memory slice.
// Holds the word width, the dmem default depth and address limit, the data
// value returned on an illegal load, and the dmem controller state type.
package mips_pkg;

    localparam int          WORD_W         = 32;
    localparam int          DMEM_DEPTH_DEF = 64;
    localparam logic [31:0] DMEM_LIMIT_DEF = 32'h0000_00FF;
    localparam logic [31:0] DMEM_ERR_DATA  = 32'hFFFF_FFFF;

    typedef enum logic {
        DM_INIT = 1'b0,
        DM_RUN  = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/mips_dmem_if.sv
// mips_dmem_if: core <-> data-memory bus. The core is the master, the memory
// is the slave. Clock and reset are carried as plain ports, not in here.
interface mips_dmem_if;
    import mips_pkg::*;

    logic              DM_WE;
    logic [31:0]       DM_ADDR;
    logic [WORD_W-1:0] DM_WR_DATA;
    logic [WORD_W-1:0] DM_RD_DATA;
    logic              DM_BUSY;
    logic              DM_ERR;

    modport master (
        output DM_WE, DM_ADDR, DM_WR_DATA,
        input  DM_RD_DATA, DM_BUSY, DM_ERR
    );

    modport slave (
        input  DM_WE, DM_ADDR, DM_WR_DATA,
        output DM_RD_DATA, DM_BUSY, DM_ERR
    );

endinterface

// File: rtl/mips_dmem_wbuf.sv
// mips_dmem_wbuf: one-entry store buffer. A store captured on one edge is
// offered for commit on the next edge; loads hitting the held word index get
// the buffered data instead of the (not yet updated) array word.
module mips_dmem_wbuf
    import mips_pkg::*;
#(
    parameter int IW = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cap,
    input  logic [IW-1:0]     i_cap_idx,
    input  logic [WORD_W-1:0] i_cap_data,
    input  logic [IW-1:0]     i_rd_idx,
    output logic              o_commit,
    output logic [IW-1:0]     o_commit_idx,
    output logic [WORD_W-1:0] o_commit_data,
    output logic              o_hit,
    output logic [WORD_W-1:0] o_fwd_data
);

    logic              r_valid;
    logic [IW-1:0]     r_idx;
    logic [WORD_W-1:0] r_data;

    // Capture a new store every edge it is offered; the old entry leaves via commit on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= i_cap;
            if (i_cap) begin
                r_idx  <= i_cap_idx;
                r_data <= i_cap_data;
            end
        end
    end

    assign o_commit      = r_valid;
    assign o_commit_idx  = r_idx;
    assign o_commit_data = r_data;
    assign o_hit         = r_valid && (r_idx == i_rd_idx);
    assign o_fwd_data    = r_data;

endmodule

// File: rtl/mips_dmem.sv
// mips_dmem: registered-read data memory with a one-entry store buffer,
// range/alignment error flag and an INIT/RUN controller.
// Optional feature: define MIPS_DMEM_CLR_EN to zero the whole array after
// reset (one word per cycle, DM_BUSY high meanwhile).
//
// state   | meaning
// DM_INIT | after reset; clear sweep (if built in), loads return 0, stores ignored
// DM_RUN  | normal load/store operation
module mips_dmem
    import mips_pkg::*;
#(
    parameter int          DEPTH_WORDS = DMEM_DEPTH_DEF,
    parameter logic [31:0] ADDR_LIMIT  = DMEM_LIMIT_DEF
) (
    input  logic          DM_CLK,
    input  logic          Z_R,
    mips_dmem_if.slave    bus
);

    localparam int IW = $clog2(DEPTH_WORDS);

    dmem_state_t       r_state;
    dmem_state_t       w_next_state;
    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
    logic [WORD_W-1:0] r_rd_data;
    logic              r_err;

    logic              w_run;
    logic              w_busy;
    logic              w_sweep_we;
    logic              w_sweep_done;
    logic [IW-1:0]     w_sweep_idx;
    logic              w_in_range;
    logic              w_misalign;
    logic [IW-1:0]     w_idx;
    logic              w_cap;
    logic              w_commit;
    logic [IW-1:0]     w_commit_idx;
    logic [WORD_W-1:0] w_commit_data;
    logic              w_hit;
    logic [WORD_W-1:0] w_fwd_data;

    assign w_in_range = (bus.DM_ADDR <= ADDR_LIMIT);
    assign w_misalign = (bus.DM_ADDR[1:0] != 2'b00);
    assign w_idx      = bus.DM_ADDR[IW+1:2];
    assign w_cap      = w_run && bus.DM_WE && w_in_range;

`ifdef MIPS_DMEM_CLR_EN
    logic [IW-1:0] r_sweep;

    // Sweep pointer walks every word once while in INIT.
    always_ff @(posedge DM_CLK or negedge Z_R) begin
        if (!Z_R)
            r_sweep <= '0;
        else if (r_state == DM_INIT)
            r_sweep <= r_sweep + 1'b1;
    end

    assign w_sweep_idx  = r_sweep;
    assign w_sweep_done = (r_sweep == IW'(DEPTH_WORDS - 1));
`else
    assign w_sweep_idx  = '0;
    assign w_sweep_done = 1'b1;
`endif

    // Controller state register.
    always_ff @(posedge DM_CLK or negedge Z_R) begin
        if (!Z_R)
            r_state <= DM_INIT;
        else
            r_state <= w_next_state;
    end

    // Leave INIT once the last word has been cleared (at once without the sweep).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DM_INIT: if (w_sweep_done) w_next_state = DM_RUN;
            DM_RUN:  w_next_state = DM_RUN;
            default: w_next_state = DM_INIT;
        endcase
    end

    // Controller outputs; busy is masked by reset so it reads 0 while Z_R is low.
    always_comb begin
        w_run      = (r_state == DM_RUN);
        w_busy     = 1'b0;
        w_sweep_we = 1'b0;
`ifdef MIPS_DMEM_CLR_EN
        w_busy     = (r_state == DM_INIT) && Z_R;
        w_sweep_we = (r_state == DM_INIT);
`endif
    end

    mips_dmem_wbuf #(
        .IW (IW)
    ) u_wbuf (
        .clk           (DM_CLK),
        .rst_n         (Z_R),
        .i_cap         (w_cap),
        .i_cap_idx     (w_idx),
        .i_cap_data    (bus.DM_WR_DATA),
        .i_rd_idx      (w_idx),
        .o_commit      (w_commit),
        .o_commit_idx  (w_commit_idx),
        .o_commit_data (w_commit_data),
        .o_hit         (w_hit),
        .o_fwd_data    (w_fwd_data)
    );

    // Single array write port: clear sweep in INIT, buffered store commit in RUN.
    always_ff @(posedge DM_CLK) begin
        if (w_sweep_we)
            r_mem[w_sweep_idx] <= '0;
        else if (w_commit)
            r_mem[w_commit_idx] <= w_commit_data;
    end

    // Registered load data and sticky error flag; only RUN updates the flag.
    always_ff @(posedge DM_CLK or negedge Z_R) begin
        if (!Z_R) begin
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else if (r_state == DM_INIT) begin
            r_rd_data <= '0;
        end else begin
            if (!bus.DM_WE) begin
                if (!w_in_range)
                    r_rd_data <= DMEM_ERR_DATA;
                else if (w_hit)
                    r_rd_data <= w_fwd_data;
                else
                    r_rd_data <= r_mem[w_idx];
            end
            if (!w_in_range || w_misalign)
                r_err <= 1'b1;
        end
    end

    assign bus.DM_RD_DATA = r_rd_data;
    assign bus.DM_BUSY    = w_busy;
    assign bus.DM_ERR     = r_err;

endmodule

// File: tb/tb_mips_dmem.sv
// tb_mips_dmem: directed checks of mips_dmem (forwarding, back-to-back
// stores, range/alignment errors, reset behaviour, optional clear sweep).
module tb_mips_dmem;

`ifdef MIPS_DMEM_CLR_EN
    localparam int EXP_BUSY = 64;
`else
    localparam int EXP_BUSY = 0;
`endif

    logic clk;
    logic z_r;
    int   n_assert;
    int   n_fail;
    int   busy_cyc;

    mips_dmem_if bus();

    mips_dmem #(
        .DEPTH_WORDS (64),
        .ADDR_LIMIT  (32'h0000_00FF)
    ) u_dut (
        .DM_CLK (clk),
        .Z_R    (z_r),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.DM_WE      = 1'b1;
        bus.DM_ADDR    = addr;
        bus.DM_WR_DATA = data;
        cyc();
    endtask

    task automatic rd(input logic [31:0] addr);
        bus.DM_WE      = 1'b0;
        bus.DM_ADDR    = addr;
        bus.DM_WR_DATA = '0;
        cyc();
    endtask

    task automatic idle();
        rd(32'h0);
    endtask

    // Assert reset (immediately or at the next falling edge), check reset
    // outputs, release at a falling edge and count busy cycles until RUN.
    task automatic apply_reset(input bit now, output int bcnt);
        if (!now) @(negedge clk);
        z_r            = 1'b0;
        bus.DM_WE      = 1'b0;
        bus.DM_ADDR    = '0;
        bus.DM_WR_DATA = '0;
        #1;
        chk("rst_rd_data", bus.DM_RD_DATA, 32'h0);
        chk("rst_busy", 32'(bus.DM_BUSY), 32'h0);
        chk("rst_err", 32'(bus.DM_ERR), 32'h0);
        @(negedge clk);
        @(negedge clk);
        z_r  = 1'b1;
        bcnt = 0;
        #1;
        for (int k = 0; k < 200; k++) begin
            if (!bus.DM_BUSY) break;
            bcnt++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        z_r            = 1'b0;
        bus.DM_WE      = 1'b0;
        bus.DM_ADDR    = '0;
        bus.DM_WR_DATA = '0;

        // Reset release, busy window, INIT contents
        apply_reset(1'b0, busy_cyc);
        chk("busy_cycles", 32'(busy_cyc), 32'(EXP_BUSY));
        chk("run_busy_low", 32'(bus.DM_BUSY), 32'h0);
`ifdef MIPS_DMEM_CLR_EN
        for (int i = 0; i < 64; i++) begin
            rd(32'(i * 4));
            chk($sformatf("clr_word_%0d", i), bus.DM_RD_DATA, 32'h0);
        end
`endif

        // Store then load on the very next cycle: forwarded from the buffer
        wr(32'h10, 32'h1234_5678);
        rd(32'h10);
        chk("fwd_next_cycle", bus.DM_RD_DATA, 32'h1234_5678);
        idle();
        rd(32'h10);
        chk("array_after_commit", bus.DM_RD_DATA, 32'h1234_5678);

        // Load data held while a store is presented
        wr(32'h2C, 32'h0000_0005);
        chk("hold_on_write", bus.DM_RD_DATA, 32'h1234_5678);

        // Back-to-back stores to the same address
        wr(32'h20, 32'h0000_000A);
        wr(32'h20, 32'h0000_000B);
        rd(32'h20);
        chk("b2b_same_fwd", bus.DM_RD_DATA, 32'h0000_000B);
        idle();
        idle();
        rd(32'h20);
        chk("b2b_same_array", bus.DM_RD_DATA, 32'h0000_000B);

        // Back-to-back stores to different addresses both land
        wr(32'h24, 32'h0000_0001);
        wr(32'h28, 32'h0000_0002);
        rd(32'h24);
        chk("b2b_diff_first", bus.DM_RD_DATA, 32'h0000_0001);
        rd(32'h28);
        chk("b2b_diff_second", bus.DM_RD_DATA, 32'h0000_0002);

        // Highest aligned legal word
        wr(32'hFC, 32'hCAFE_F00D);
        idle();
        rd(32'hFC);
        chk("top_word", bus.DM_RD_DATA, 32'hCAFE_F00D);
        chk("no_err_yet", 32'(bus.DM_ERR), 32'h0);

        // Misaligned load proceeds on the aligned word and flags an error
        wr(32'h10, 32'h0000_0055);
        rd(32'h13);
        chk("misalign_data", bus.DM_RD_DATA, 32'h0000_0055);
        chk("misalign_err", 32'(bus.DM_ERR), 32'h1);
        idle();
        idle();
        chk("err_sticky_a", 32'(bus.DM_ERR), 32'h1);

        // Out-of-range load and store after a fresh reset
        apply_reset(1'b0, busy_cyc);
        chk("err_cleared_by_reset", 32'(bus.DM_ERR), 32'h0);
        wr(32'h04, 32'h0404_0404);
        idle();
        rd(32'h100);
        chk("oor_rd_data", bus.DM_RD_DATA, 32'hFFFF_FFFF);
        chk("oor_rd_err", 32'(bus.DM_ERR), 32'h1);
        wr(32'h104, 32'hDEAD_BEEF);
        idle();
        rd(32'h04);
        chk("oor_wr_dropped", bus.DM_RD_DATA, 32'h0404_0404);
        chk("err_sticky_b", 32'(bus.DM_ERR), 32'h1);

        // Reset between capture and commit discards the pending store
        apply_reset(1'b0, busy_cyc);
        wr(32'h30, 32'h0000_0011);
        idle();
        wr(32'h30, 32'h0000_0077);
        apply_reset(1'b1, busy_cyc);
        chk("busy_cycles_2", 32'(busy_cyc), 32'(EXP_BUSY));
        rd(32'h30);
`ifdef MIPS_DMEM_CLR_EN
        chk("pending_discarded", bus.DM_RD_DATA, 32'h0000_0000);
`else
        chk("pending_discarded", bus.DM_RD_DATA, 32'h0000_0011);
`endif
        chk("err_after_reset", 32'(bus.DM_ERR), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_dmem.md
MIPS_DMEM -- requirements
Module: mips_dmem

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 64, giving the number of 32-bit words in the internal array.
REQ-002 The block SHALL have parameter ADDR_LIMIT, default 32'h000000FF, giving the highest legal byte address.
REQ-003 The block SHALL have port DM_CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Z_R, input, 1 bit, reset: asynchronous, active-low.
REQ-005 The block SHALL have port DM_WE, input, 1 bit, the write enable from the core.
REQ-006 The block SHALL have port DM_ADDR, input, 32 bits, the byte address from the core.
REQ-007 The block SHALL have port DM_WR_DATA, input, 32 bits, the store data.
REQ-008 The block SHALL have port DM_RD_DATA, output, 32 bits, the load data.
REQ-009 The block SHALL have port DM_BUSY, output, 1 bit; high while the block is not accepting accesses.
REQ-010 The block SHALL have port DM_ERR, output, 1 bit, a sticky access-error flag.

Function
REQ-011 Word index SHALL be DM_ADDR[31:2]; address is in range iff DM_ADDR <= ADDR_LIMIT.
REQ-012 Read SHALL be registered: DM_RD_DATA updated at each rising edge from DM_ADDR sampled at that edge when DM_WE=0; 1-cycle latency; held when DM_WE=1.
REQ-013 Out-of-range read SHALL return 32'hFFFFFFFF and set DM_ERR.
REQ-014 Write SHALL be captured into a one-entry write buffer (addr, data, valid) at the edge where DM_WE=1, and committed to the array at the following edge.
REQ-015 Out-of-range write SHALL be dropped, never enter the buffer, and set DM_ERR.
REQ-016 Misaligned access (DM_ADDR[1:0]!=0) SHALL proceed on the aligned word and set DM_ERR.
REQ-017 Read whose word index matches a valid buffer entry SHALL return buffer data (forwarding), not array data.
REQ-018 Back-to-back writes SHALL commit the old entry and capture the new one on the same edge; same-address back-to-back writes SHALL leave the newest data visible.
REQ-019 DM_ERR SHALL be cleared only by reset.
REQ-020 FSM states SHALL be INIT and RUN; INIT->RUN after the clear sweep completes (REQ-025) or immediately when the sweep is compiled out.
REQ-021 In INIT: DM_BUSY=1, writes ignored, reads return 32'h00000000, DM_ERR not updated.

Reset
REQ-022 While Z_R=0: DM_RD_DATA=0, DM_BUSY=0, DM_ERR=0, buffer valid=0, FSM=INIT, sweep counter=0.
REQ-023 Reset asserted mid-operation SHALL discard any pending buffered write; the array need not be cleared by reset itself.
REQ-024 On the first edge after Z_R rises, FSM SHALL act per REQ-020.

Configuration
REQ-025 With macro MIPS_DMEM_CLR_EN defined: INIT writes zero to word 0..DEPTH_WORDS-1, one per cycle, DM_BUSY=1 throughout, RUN entered after DEPTH_WORDS cycles.
REQ-026 Without MIPS_DMEM_CLR_EN: no sweep, INIT lasts one cycle, DM_BUSY stays 0, array contents after reset undefined.

Structure
REQ-027 Shared package mips_pkg SHALL hold word width (32), DMEM default depth/limit constants, the error-data constant 32'hFFFFFFFF, and the dmem FSM state enum.
REQ-028 The write buffer with match/forward logic SHALL be sub-module mips_dmem_wbuf; array, FSM and error logic stay in mips_dmem.

Verification
REQ-029 Bench SHALL cover: write 0x12345678 to 0x10, read 0x10 on the very next cycle -> DM_RD_DATA=0x12345678 via forwarding.
REQ-030 Bench SHALL cover: writes 0xA then 0xB to 0x20 back-to-back, read 0x20 next cycle and again 3 cycles later -> 0xB both times.
REQ-031 Bench SHALL cover: read 0x100 -> DM_RD_DATA=0xFFFFFFFF, DM_ERR=1 and stays 1; write to 0x104 -> array unchanged.
REQ-032 Bench SHALL cover: read 0x13 after writing 0x55 to 0x10 -> 0x55, DM_ERR=1.
REQ-033 Bench SHALL cover (MIPS_DMEM_CLR_EN): release reset -> DM_BUSY=1 for exactly 64 cycles, all words read 0 afterwards; without macro DM_BUSY never rises.
REQ-034 Bench SHALL cover: write 0x77 to 0x30, assert Z_R in the next cycle before commit -> after reset, the 0x77 store is not observed.
